// File: rtl/axi_ni_resp_scheduler.sv
// axi_ni_resp_scheduler: picks the next AXI B/R response to send, alternating classes and round-robin within a class
module axi_ni_resp_scheduler #(
  parameter int MAX_SUPPORTED_IDS = 16,
  parameter int IDWD = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [MAX_SUPPORTED_IDS-1:0] br_rempty,
  input  logic [MAX_SUPPORTED_IDS-1:0] rr_rempty,
  input  logic [MAX_SUPPORTED_IDS-1:0] wrr_rempty,
  input  logic [MAX_SUPPORTED_IDS-1:0] rdr_rempty,
  input  logic                         last_beat,
  input  logic                         tx_gone,
  output logic [MAX_SUPPORTED_IDS-1:0] br_rinc,
  output logic [MAX_SUPPORTED_IDS-1:0] rr_rinc,
  output logic [MAX_SUPPORTED_IDS-1:0] wrr_rinc,
  output logic [MAX_SUPPORTED_IDS-1:0] rdr_rinc,
  output logic [IDWD-1:0]              curr_tid,
  output logic                         packet_type_is_read,
  output logic                         sample_header,
  output logic                         sample_payload,
  output logic                         send_message,
  output logic                         busy
);
  localparam int N = MAX_SUPPORTED_IDS;
  typedef enum logic [2:0] {IDLE, SAMPLE, SEND, POP, BURST_WAIT} state_t;
  state_t state, state_n;
  logic [N-1:0] wr_elig, rd_elig, pop_vec;
  logic [IDWD-1:0] wr_start, rd_start, wr_sel, rd_sel, tid_nxt;
  logic wr_any, rd_any, grant_read, last_read, lb_q, done;
  // First set bit of elig at or after start, wrapping modulo N.
  function automatic logic [IDWD-1:0] rr_pick(input logic [N-1:0] elig, input logic [IDWD-1:0] start);
    logic [IDWD-1:0] sel;
    logic found;
    logic [IDWD:0] idx;
    sel = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, start} + (IDWD+1)'(k);
      if (idx >= (IDWD+1)'(N)) idx = idx - (IDWD+1)'(N);
      if (!found && elig[idx[IDWD-1:0]]) begin
        found = 1'b1;
        sel = idx[IDWD-1:0];
      end
    end
    return sel;
  endfunction
  assign wr_elig = ~br_rempty & ~wrr_rempty;
  assign rd_elig = ~rr_rempty & ~rdr_rempty;
  assign wr_any = |wr_elig;
  assign rd_any = |rd_elig;
  assign wr_sel = rr_pick(wr_elig, wr_start);
  assign rd_sel = rr_pick(rd_elig, rd_start);
  assign grant_read = rd_any && (!wr_any || !last_read);
  assign done = state == POP && (!packet_type_is_read || lb_q);
  assign tid_nxt = (curr_tid == IDWD'(N-1)) ? '0 : curr_tid + 1'b1;
  assign pop_vec = (state == POP) ? (N'(1) << curr_tid) : '0;
  assign br_rinc = packet_type_is_read ? '0 : pop_vec;
  assign wrr_rinc = packet_type_is_read ? '0 : pop_vec;
  assign rr_rinc = packet_type_is_read ? pop_vec : '0;
  assign rdr_rinc = (packet_type_is_read && lb_q) ? pop_vec : '0;
  assign sample_header = state == SAMPLE;
  assign sample_payload = state == SAMPLE;
  assign send_message = state == SEND;
  assign busy = state != IDLE;
  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // Next-state: a read burst stays locked on its ID until RLAST has been popped.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = (wr_any || rd_any) ? SAMPLE : IDLE;
      SAMPLE:     state_n = SEND;
      SEND:       state_n = tx_gone ? POP : SEND;
      POP:        state_n = (!packet_type_is_read || lb_q) ? IDLE : BURST_WAIT;
      BURST_WAIT: state_n = !rr_rempty[curr_tid] ? SAMPLE : BURST_WAIT;
      default:    state_n = IDLE;
    endcase
  end
  // Grant capture, RLAST capture and arbitration history, advanced only on packet completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curr_tid <= '0;
      packet_type_is_read <= 1'b0;
      lb_q <= 1'b0;
      wr_start <= '0;
      rd_start <= '0;
      last_read <= 1'b1;
    end else begin
      if (state == IDLE && (wr_any || rd_any)) begin
        curr_tid <= grant_read ? rd_sel : wr_sel;
        packet_type_is_read <= grant_read;
      end
      if (state == SAMPLE) lb_q <= last_beat;
      if (done) begin
        last_read <= packet_type_is_read;
        if (packet_type_is_read) rd_start <= tid_nxt;
        else wr_start <= tid_nxt;
      end
    end
  end
endmodule

// File: tb/tb_axi_ni_resp_scheduler.sv
// tb_axi_ni_resp_scheduler: directed self-checking bench for the response scheduler
module tb_axi_ni_resp_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] br_e = '1, rr_e = '1, wrr_e = '1, rdr_e = '1;
  logic last_beat = 1'b0, tx_gone = 1'b0;
  logic [15:0] br_rinc, rr_rinc, wrr_rinc, rdr_rinc;
  logic [3:0] curr_tid;
  logic packet_type_is_read, sample_header, sample_payload, send_message, busy;
  int checks = 0, failures = 0;
  logic bad_onehot = 1'b0;

  axi_ni_resp_scheduler #(.MAX_SUPPORTED_IDS(16), .IDWD(4)) dut (
    .clk(clk), .rst(rst),
    .br_rempty(br_e), .rr_rempty(rr_e), .wrr_rempty(wrr_e), .rdr_rempty(rdr_e),
    .last_beat(last_beat), .tx_gone(tx_gone),
    .br_rinc(br_rinc), .rr_rinc(rr_rinc), .wrr_rinc(wrr_rinc), .rdr_rinc(rdr_rinc),
    .curr_tid(curr_tid), .packet_type_is_read(packet_type_is_read),
    .sample_header(sample_header), .sample_payload(sample_payload),
    .send_message(send_message), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!$onehot0(br_rinc) || !$onehot0(rr_rinc) || !$onehot0(wrr_rinc) || !$onehot0(rdr_rinc)) bad_onehot = 1'b1;

  task automatic do_reset();
    rst = 1'b1;
    br_e = '1; rr_e = '1; wrr_e = '1; rdr_e = '1;
    last_beat = 1'b0; tx_gone = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one packet from grant to POP; returns at the negedge of the POP cycle.
  task automatic serve(input logic lb, input int delay, output logic [3:0] tid, output logic rd,
                       output logic sh2, output logic [63:0] pops, output bit ok);
    ok = 1'b0; tid = '0; rd = 1'b0; sh2 = 1'b0; pops = '0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = sample_header && sample_payload;
    end
    if (!ok) return;
    tid = curr_tid;
    rd = packet_type_is_read;
    last_beat = lb;
    @(negedge clk);
    sh2 = sample_header | sample_payload;
    ok = send_message;
    repeat (delay) begin
      @(negedge clk);
      if (!send_message) ok = 1'b0;
    end
    tx_gone = 1'b1;
    @(negedge clk);
    tx_gone = 1'b0;
    last_beat = 1'b0;
    pops = {br_rinc, rr_rinc, wrr_rinc, rdr_rinc};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy, send_message, sample_header, sample_payload, packet_type_is_read, curr_tid} !== 9'h0) begin
      failures++; $display("FAIL reset_ctrl got=%0h exp=0", {busy, send_message, sample_header, sample_payload, packet_type_is_read, curr_tid});
    end
    checks++;
    if ({br_rinc, rr_rinc, wrr_rinc, rdr_rinc} !== 64'h0) begin
      failures++; $display("FAIL reset_rinc got=%0h exp=0", {br_rinc, rr_rinc, wrr_rinc, rdr_rinc});
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_single_write();
    logic [3:0] tid; logic rd, sh2; logic [63:0] p; bit ok;
    do_reset();
    br_e[3] = 1'b0; wrr_e[3] = 1'b0;
    serve(1'b0, 3, tid, rd, sh2, p, ok);
    br_e[3] = 1'b1; wrr_e[3] = 1'b1;
    checks++;
    if (!ok) begin failures++; $display("FAIL single_flow got=0 exp=1"); end
    checks++;
    if ({tid, rd} !== {4'd3, 1'b0}) begin failures++; $display("FAIL single_grant got=%0h exp=%0h", {tid, rd}, {4'd3, 1'b0}); end
    checks++;
    if (sh2 !== 1'b0) begin failures++; $display("FAIL single_strobe_width got=%0b exp=0", sh2); end
    checks++;
    if (p !== {16'h0008, 16'h0, 16'h0008, 16'h0}) begin failures++; $display("FAIL single_pop got=%0h exp=%0h", p, {16'h0008, 16'h0, 16'h0008, 16'h0}); end
    @(negedge clk);
    checks++;
    if ({busy, br_rinc, wrr_rinc} !== 33'h0) begin failures++; $display("FAIL single_after got=%0h exp=0", {busy, br_rinc, wrr_rinc}); end
  endtask

  task automatic test_rr_write();
    logic [3:0] tid; logic rd, sh2; logic [63:0] p; bit ok;
    logic [3:0] exp_tid [4] = '{4'd2, 4'd5, 4'd2, 4'd5};
    do_reset();
    br_e[2] = 1'b0; wrr_e[2] = 1'b0; br_e[5] = 1'b0; wrr_e[5] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      serve(1'b0, 0, tid, rd, sh2, p, ok);
      checks++;
      if (!ok || tid !== exp_tid[i] || p[63:48] !== (16'h1 << exp_tid[i])) begin
        failures++; $display("FAIL rr_write[%0d] got=%0h ok=%0b pop=%0h exp=%0h", i, tid, ok, p[63:48], exp_tid[i]);
      end
    end
  endtask

  task automatic test_alternation();
    logic [3:0] tid; logic rd, sh2; logic [63:0] p; bit ok;
    logic exp_rd [3] = '{1'b0, 1'b1, 1'b0};
    logic [63:0] exp_p [3] = '{{16'h2, 16'h0, 16'h2, 16'h0}, {16'h0, 16'h2, 16'h0, 16'h2}, {16'h2, 16'h0, 16'h2, 16'h0}};
    do_reset();
    br_e[1] = 1'b0; wrr_e[1] = 1'b0; rr_e[1] = 1'b0; rdr_e[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      serve(1'b1, 0, tid, rd, sh2, p, ok);
      checks++;
      if (!ok || tid !== 4'd1 || rd !== exp_rd[i] || p !== exp_p[i]) begin
        failures++; $display("FAIL alternation[%0d] got=tid%0h rd%0b pop%0h exp=rd%0b pop%0h", i, tid, rd, p, exp_rd[i], exp_p[i]);
      end
    end
  endtask

  task automatic test_burst();
    logic [3:0] tid; logic rd, sh2; logic [63:0] p; bit ok;
    logic lbs [3] = '{1'b0, 1'b0, 1'b1};
    do_reset();
    rr_e[7] = 1'b0; rdr_e[7] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      serve(lbs[i], 1, tid, rd, sh2, p, ok);
      br_e[0] = 1'b0; wrr_e[0] = 1'b0;
      checks++;
      if (!ok || {tid, rd} !== {4'd7, 1'b1} || p !== {16'h0, 16'h0080, 16'h0, (lbs[i] ? 16'h0080 : 16'h0)}) begin
        failures++; $display("FAIL burst_beat[%0d] got=tid%0h rd%0b pop%0h exp=tid7 rd1", i, tid, rd, p);
      end
    end
    rr_e[7] = 1'b1; rdr_e[7] = 1'b1;
    serve(1'b0, 0, tid, rd, sh2, p, ok);
    checks++;
    if (!ok || {tid, rd} !== {4'd0, 1'b0} || p !== {16'h1, 16'h0, 16'h1, 16'h0}) begin
      failures++; $display("FAIL burst_then_write got=tid%0h rd%0b pop%0h exp=tid0 rd0", tid, rd, p);
    end
    br_e[0] = 1'b1; wrr_e[0] = 1'b1;
  endtask

  task automatic test_burst_wait();
    logic [3:0] tid; logic rd, sh2; logic [63:0] p; bit ok;
    logic hold_bad;
    do_reset();
    rr_e[7] = 1'b0; rdr_e[7] = 1'b0;
    serve(1'b0, 0, tid, rd, sh2, p, ok);
    rr_e[7] = 1'b1;
    br_e[4] = 1'b0; wrr_e[4] = 1'b0;
    checks++;
    if (!ok || {tid, rd} !== {4'd7, 1'b1} || p[15:0] !== 16'h0) begin
      failures++; $display("FAIL bw_first got=tid%0h rd%0b rdr%0h exp=tid7 rd1 rdr0", tid, rd, p[15:0]);
    end
    hold_bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (send_message !== 1'b0 || busy !== 1'b1 || sample_header !== 1'b0 || curr_tid !== 4'd7) hold_bad = 1'b1;
    end
    checks++;
    if (hold_bad) begin failures++; $display("FAIL bw_hold got=1 exp=0"); end
    rr_e[7] = 1'b0;
    serve(1'b1, 0, tid, rd, sh2, p, ok);
    checks++;
    if (!ok || {tid, rd} !== {4'd7, 1'b1} || p !== {16'h0, 16'h0080, 16'h0, 16'h0080}) begin
      failures++; $display("FAIL bw_resume got=tid%0h rd%0b pop%0h exp=tid7 rd1", tid, rd, p);
    end
    rr_e[7] = 1'b1; rdr_e[7] = 1'b1; br_e[4] = 1'b1; wrr_e[4] = 1'b1;
  endtask

  task automatic test_reset_mid_send();
    logic [3:0] tid; logic rd, sh2; logic [63:0] p; bit ok;
    logic rinc_bad;
    do_reset();
    br_e[9] = 1'b0; wrr_e[9] = 1'b0;
    serve(1'b0, 0, tid, rd, sh2, p, ok);
    br_e[9] = 1'b1; wrr_e[9] = 1'b1;
    br_e[1] = 1'b0; wrr_e[1] = 1'b0; br_e[12] = 1'b0; wrr_e[12] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = send_message;
    end
    checks++;
    if (!ok || curr_tid !== 4'd12) begin failures++; $display("FAIL pre_reset_grant got=%0h ok=%0b exp=c", curr_tid, ok); end
    rst = 1'b1;
    tx_gone = 1'b1;
    #1;
    checks++;
    if ({busy, send_message, sample_header, packet_type_is_read, curr_tid} !== 8'h0) begin
      failures++; $display("FAIL mid_send_reset got=%0h exp=0", {busy, send_message, sample_header, packet_type_is_read, curr_tid});
    end
    rinc_bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if ({br_rinc, rr_rinc, wrr_rinc, rdr_rinc} !== 64'h0) rinc_bad = 1'b1;
    end
    tx_gone = 1'b0;
    rst = 1'b0;
    checks++;
    if (rinc_bad) begin failures++; $display("FAIL mid_send_rinc got=1 exp=0"); end
    serve(1'b0, 0, tid, rd, sh2, p, ok);
    checks++;
    if (!ok || {tid, rd} !== {4'd1, 1'b0}) begin failures++; $display("FAIL post_reset_grant got=tid%0h rd%0b exp=tid1 rd0", tid, rd); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_rr_write();
    test_alternation();
    test_burst();
    test_burst_wait();
    test_reset_mid_send();
    checks++;
    if (bad_onehot !== 1'b0) begin failures++; $display("FAIL rinc_onehot got=1 exp=0"); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_ni_resp_scheduler.md
AXI_NI_RESP_SCHEDULER -- requirements
Module: axi_ni_resp_scheduler

Interface
REQ-001 SHALL have parameter MAX_SUPPORTED_IDS, default 16, number of per-ID response queue pairs scheduled.
REQ-002 SHALL have parameter IDWD, default 4, width of curr_tid; 2**IDWD >= MAX_SUPPORTED_IDS.
REQ-003 SHALL have ports: clk  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: br_rempty, rr_rempty, wrr_rempty, rdr_rempty  in  MAX_SUPPORTED_IDS each  per-ID empty flags of the B data, R data, write-request-record and read-request-record queues.
REQ-006 SHALL have ports: last_beat  in  1  RLAST of the R queue head for curr_tid.
REQ-007 SHALL have ports: tx_gone  in  1  one-cycle pulse, current response packet fully transmitted.
REQ-008 SHALL have ports: br_rinc, rr_rinc, wrr_rinc, rdr_rinc  out  MAX_SUPPORTED_IDS each  one-hot queue pop pulses.
REQ-009 SHALL have ports: curr_tid  out  IDWD  ID being served.
REQ-010 SHALL have ports: packet_type_is_read  out  1  0 = write response, 1 = read response.
REQ-011 SHALL have ports: sample_header, sample_payload  out  1  one-cycle capture strobes for header/payload registers.
REQ-012 SHALL have ports: send_message  out  1  level request to the transmit controller.
REQ-013 SHALL have ports: busy  out  1  high in every state except IDLE.

Function
REQ-014 Write ID i SHALL be eligible iff !br_rempty[i] && !wrr_rempty[i]; read ID i eligible iff !rr_rempty[i] && !rdr_rempty[i].
REQ-015 States SHALL be IDLE, SAMPLE, SEND, POP, BURST_WAIT; encoding free.
REQ-016 IDLE: if any ID is eligible, SHALL register curr_tid and packet_type_is_read and go to SAMPLE next cycle; otherwise stay in IDLE.
REQ-017 Class choice SHALL alternate: the class opposite to the last granted class wins when both have eligible IDs; a lone eligible class wins outright.
REQ-018 Within a class, SHALL pick round-robin: first eligible ID at or after (that class's last granted ID + 1) mod MAX_SUPPORTED_IDS, wrapping.
REQ-019 Each class SHALL keep an independent round-robin pointer, updated only when a packet completes (REQ-023).
REQ-020 SAMPLE: SHALL assert sample_header and sample_payload for exactly one cycle, capture last_beat internally, then go to SEND.
REQ-021 SEND: SHALL hold send_message high until tx_gone; on tx_gone go to POP. tx_gone in any other state SHALL be ignored.
REQ-022 POP, one cycle: write SHALL pulse br_rinc[curr_tid] and wrr_rinc[curr_tid]; read SHALL pulse rr_rinc[curr_tid], plus rdr_rinc[curr_tid] only if the captured last_beat is 1.
REQ-023 After POP: write, or read with captured last_beat=1, SHALL go to IDLE and update the class pointer and last class; read with last_beat=0 SHALL go to BURST_WAIT.
REQ-024 BURST_WAIT: SHALL keep curr_tid and class locked; go to SAMPLE when !rr_resmpty[curr_tid]; no other ID or class is served mid-burst.
REQ-025 At most one bit of each rinc vector SHALL be high in any cycle; no rinc asserted outside POP.
REQ-026 Minimum grant-to-grant spacing SHALL be 4 cycles (IDLE, SAMPLE, SEND with tx_gone in its first cycle, POP).
REQ-027 Queue-empty changes during SAMPLE/SEND/POP SHALL not alter curr_tid or packet_type_is_read.

Reset
REQ-028 On rst: state SHALL be IDLE; all rinc = 0; sample_header = sample_payload = send_message = busy = 0; curr_tid = 0; packet_type_is_read = 0.
REQ-029 On rst: both round-robin pointers SHALL be set so ID 0 is searched first; last class = read, so write wins the first tie.
REQ-030 Reset asserted mid-burst or mid-SEND SHALL abandon the packet with no pop pulse.

Verification
REQ-031 Write ID 3 only eligible -> curr_tid=3, type=0; SAMPLE strobes 1 cycle; send_message until tx_gone; then single-cycle br_rinc=wrr_rinc=16'h0008.
REQ-032 Write IDs 2 and 5 both eligible persistently, 4 packets -> grant order 2,5,2,5.
REQ-033 Write ID 1 and read ID 1 eligible at reset exit -> write first, then read, then write (alternation).
REQ-034 Read ID 7, 3-beat burst, last_beat 0,0,1 -> three SAMPLE/SEND/POP rounds on ID 7; rr_rinc pulses 3 times, rdr_rinc once (third); write ID 0 eligible throughout is not served until burst ends.
REQ-035 Read ID 7 burst, R queue empty after beat 1 for 10 cycles -> BURST_WAIT holds, send_message=0, busy=1; resumes on ID 7 when refilled.
REQ-036 rst pulse during SEND -> all outputs at reset values next edge; no rinc pulse; ID 0 searched first afterwards.
